// File: rtl/enemy_director_if.sv
// enemy_director_if
//   Bundles the room-controller signals exchanged between enemy_director and
//   the room/enemy side (frame timing, room select, per-slot enemy status and
//   the director's outputs).
//   Ports (signals):
//     frame_clk     vertical-sync frame clock (asynchronous to Clk)
//     room          room index, sampled on room_load
//     room_load     one-Clk pulse requesting a new room
//     enemy_active  per-slot active flags from the Enemy instances
//     hit           per-slot one-Clk sword-hit strobes
//     initialize    broadcast initialize to all Enemy instances
//     room_q        latched room index
//     dir           per-slot walk direction, slot i at [3i+2:3i]
//     damage        held per-slot damage requests
//     alive_count   population count of enemy_active
//     room_clear    high when the current room has no live enemies
//   Modports: slave = enemy_director side, master = room/enemy side.
interface enemy_director_if #(
   parameter int NUM_ENEMIES = 5
);
   logic                       frame_clk;
   logic [2:0]                 room;
   logic                       room_load;
   logic [NUM_ENEMIES-1:0]     enemy_active;
   logic [NUM_ENEMIES-1:0]     hit;
   logic                       initialize;
   logic [2:0]                 room_q;
   logic [3*NUM_ENEMIES-1:0]   dir;
   logic [NUM_ENEMIES-1:0]     damage;
   logic [2:0]                 alive_count;
   logic                       room_clear;

   modport master (
      output frame_clk, room, room_load, enemy_active, hit,
      input  initialize, room_q, dir, damage, alive_count, room_clear
   );

   modport slave (
      input  frame_clk, room, room_load, enemy_active, hit,
      output initialize, room_q, dir, damage, alive_count, room_clear
   );
endinterface

// File: rtl/enemy_director.sv
// enemy_director
//   Room-level controller for the Enemy instances. On a room load it holds
//   initialize for INIT_FRAMES frame edges, then hands each live enemy a
//   pseudo-random walk direction (re-rolled every DIR_HOLD_FRAMES frame edges)
//   and turns one-cycle hit strobes into damage requests held until the next
//   frame edge. Reports live-enemy count and a room-cleared flag.
//   Ports:
//     Clk    system clock
//     Reset  synchronous, active-high reset
//     bus    enemy_director_if.slave (frame_clk, room, room_load,
//            enemy_active, hit in; initialize, room_q, dir, damage,
//            alive_count, room_clear out)
module enemy_director #(
   parameter int          NUM_ENEMIES     = 5,
   parameter int          DIR_HOLD_FRAMES = 32,
   parameter int          INIT_FRAMES     = 2,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input logic              Clk,
   input logic              Reset,
   enemy_director_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, CLEAR} state_t;

   state_t                     state;
   logic                       frame_clk_d;
   logic                       fe;
   logic [2:0]                 init_cnt;
   logic [7:0]                 hold_cnt;
   logic [15:0]                lfsr;
   logic [15:0]                lfsr_next;
   logic [3*NUM_ENEMIES-1:0]   dir_raw;
   logic [3*NUM_ENEMIES-1:0]   dir_out;
   logic [NUM_ENEMIES-1:0]     damage_r;
   logic [2:0]                 room_q_r;
   logic                       initialize_r;
   logic                       room_clear_r;
   logic [2:0]                 alive;

   assign fe = bus.frame_clk & ~frame_clk_d;

   // Fibonacci LFSR, taps 16,14,13,11; shifts left with feedback into bit 0.
   assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   always_comb begin
      alive = '0;
      for (int i = 0; i < NUM_ENEMIES; i++)
         alive = alive + 3'(bus.enemy_active[i]);
   end

   // Rolled directions are only shown while running, outside the safe room,
   // and only for slots whose enemy is still alive.
   always_comb begin
      dir_out = '0;
      if (state == RUN && room_q_r != 3'd0) begin
         for (int i = 0; i < NUM_ENEMIES; i++)
            if (bus.enemy_active[i])
               dir_out[3*i +: 3] = dir_raw[3*i +: 3];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         frame_clk_d  <= 1'b0;
         room_q_r     <= '0;
         initialize_r <= 1'b0;
         dir_raw      <= '0;
         damage_r     <= '0;
         room_clear_r <= 1'b0;
         init_cnt     <= '0;
         hold_cnt     <= '0;
         lfsr         <= LFSR_SEED;
      end else begin
         frame_clk_d <= bus.frame_clk;
         // A room load overrides whatever the FSM would do with a same-cycle fe.
         if (bus.room_load) begin
            room_q_r     <= bus.room;
            state        <= LOAD;
            init_cnt     <= '0;
            damage_r     <= '0;
            dir_raw      <= '0;
            initialize_r <= 1'b1;
            room_clear_r <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               LOAD: begin
                  if (fe) begin
                     init_cnt <= init_cnt + 3'd1;
                     if (init_cnt + 3'd1 == 3'(INIT_FRAMES)) begin
                        state        <= RUN;
                        initialize_r <= 1'b0;
                        // Zero hold forces a roll on the first RUN frame edge.
                        hold_cnt     <= '0;
                     end
                  end
               end
               RUN: begin
                  // A hit in the same cycle as fe wins over the fe clear.
                  damage_r <= (damage_r & ~{NUM_ENEMIES{fe}})
                              | (bus.hit & bus.enemy_active);
                  if (fe) begin
                     lfsr <= lfsr_next;
                     if (hold_cnt == 8'd0) begin
                        for (int i = 0; i < NUM_ENEMIES; i++)
                           dir_raw[3*i +: 3] <= {1'b0, lfsr[2*i +: 2]} + 3'd1;
                        hold_cnt <= 8'(DIR_HOLD_FRAMES - 1);
                     end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                     end
                     if (bus.enemy_active == '0) begin
                        state        <= CLEAR;
                        room_clear_r <= 1'b1;
                        damage_r     <= '0;
                     end
                  end
               end
               CLEAR: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.initialize  = initialize_r;
   assign bus.room_q      = room_q_r;
   assign bus.dir         = dir_out;
   assign bus.damage      = damage_r;
   assign bus.alive_count = alive;
   assign bus.room_clear  = room_clear_r;

endmodule

// File: doc/enemy_director.md
Name: enemy_director

Overview:
Room-level controller for the five Enemy instances. On each room load it holds every enemy's initialize line across a set number of frame edges. It then issues a pseudo-random walk direction to each live enemy and converts one-cycle hit strobes into damage requests that are held until a frame edge consumes them. It reports the live-enemy count and a room-cleared flag to the door/room logic.

Parameters:
NUM_ENEMIES, 5, number of enemy slots; slot i drives the Enemy instance with number = i+1.
DIR_HOLD_FRAMES, 32, frame edges between direction re-rolls (legal range 1..255).
INIT_FRAMES, 2, frame edges for which initialize is held during a load (legal range 1..7).
LFSR_SEED, 16'hACE1, LFSR value after reset; must be non-zero.

Ports:
Clk  in  1  system clock.
Reset  in  1  synchronous, active-high reset.
frame_clk  in  1  vertical-sync frame clock, asynchronous to the frame logic; rising edge detected on Clk.
room  in  3  room index; sampled on room_load.
room_load  in  1  one-Clk pulse requesting a new room.
enemy_active  in  NUM_ENEMIES  active flags returned by the Enemy instances.
hit  in  NUM_ENEMIES  one-Clk sword-hit strobes, one per slot.
initialize  out  1  broadcast initialize to all Enemy instances.
room_q  out  3  latched room index, fanned out to the Enemy room inputs.
dir  out  3*NUM_ENEMIES  per-slot direction; slot i occupies bits [3i+2:3i]; 0 = stop, 1 = left, 2 = right, 3 = down, 4 = up.
damage  out  NUM_ENEMIES  held damage requests.
alive_count  out  3  population count of enemy_active.
room_clear  out  1  high when the current room has no live enemies.

Behaviour:
- Frame edge detection: fe = frame_clk & ~frame_clk_d, where frame_clk_d is frame_clk registered on Clk.
- Reset: state=IDLE, room_q=0, initialize=0, dir=0, damage=0, room_clear=0, frame counters=0, lfsr=LFSR_SEED.
- alive_count is combinational popcount(enemy_active) in every state, including reset.
- FSM states: IDLE, LOAD, RUN, CLEAR.
- room_load in any state:
  - room_q <= room; state <= LOAD; init_cnt <= 0; pending damage cleared; dir <= 0.
  - room_load takes priority over any fe in the same cycle.
- LOAD:
  - initialize=1; damage forced to 0; room_clear=0.
  - Each fe increments init_cnt.
  - On the fe that brings init_cnt to INIT_FRAMES: state <= RUN, hold_cnt <= 0 (forces a direction roll on the first RUN frame edge).
- RUN:
  - initialize=0.
  - On fe: lfsr advances one step (16-bit Fibonacci, taps 16,14,13,11; shift left, feedback into bit 0).
  - On fe with hold_cnt==0: dir slot i <= {1'b0, lfsr[2i+1:2i]} + 1, using the pre-advance lfsr value; hold_cnt <= DIR_HOLD_FRAMES-1.
  - On fe with hold_cnt!=0: hold_cnt decrements; dir unchanged.
  - Slots with enemy_active[i]=0 always output dir 0.
  - room_q==0 (safe room): all dir=0.
  - On fe with enemy_active==0: state <= CLEAR.
- CLEAR: room_clear=1; dir=0; damage=0; state left only via room_load.
- Damage in RUN:
  - hit[i] & enemy_active[i] sets pend[i]; damage = pend (registered).
  - pend[i] clears on fe, unless hit[i] is set in the same cycle; set wins, and the request is held to the next fe.
  - Hits in IDLE, LOAD or CLEAR are ignored.
- Reset asserted mid-LOAD or mid-RUN returns to the reset values on the next Clk.

Test Plan:
1. Reset, then room_load with room=1, INIT_FRAMES=2 -> room_q=1; initialize=1 for exactly 2 fe; state RUN after the second fe; dir rolled at the third fe from seed 16'hACE1 (slot0 = (ACE1&3)+1 = 2).
2. RUN with all enemies active, DIR_HOLD_FRAMES=32 -> dir changes only every 32nd fe; LFSR sequence matches the reference model over 200 frames; all dir values within 1..4.
3. hit[2] pulsed mid-frame -> damage[2]=1 from the next Clk until the next fe, then 0; hit[2] coinciding with fe -> damage[2] held through one further fe.
4. enemy_active drops 5'b11111 -> 5'b00000 over several frames -> alive_count tracks 5..0; at the fe with zero: room_clear=1, all dir=0; a hit in CLEAR produces no damage.
5. room_load with room=0 -> after INIT_FRAMES all dir=0; enemy_active=0 drives CLEAR on the next fe.
6. room_load mid-LOAD, and Reset mid-RUN -> init_cnt restarts at 0 with the new room_q; Reset forces all outputs to their reset values on the next Clk.
